// File: rtl/demux_dispatcher.sv
// Single-entry dispatcher in front of a 4-way demux: captures one word, then
// delivers it to an addressed or round-robin-chosen sink, dropping it on timeout.
module demux_dispatcher #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             rr_mode,
  input  logic [3:0]       out_ready,
  output logic [3:0]       out_valid,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic             drop_err,
  input  logic             clear_err,
  output logic [CNT_W-1:0] sent_count
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned TO_M1  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [1:0]         dest_q, dest_d;
  logic               mode_q, mode_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]         last_sel_q, last_sel_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;

  logic               hit_c;
  logic [1:0]         tgt_c;
  logic [1:0]         idx_c;
  logic               xfer_c;
  logic               timeout_c;

  // Target selection: latched dest, or first ready sink scanning from rr_ptr.
  always_comb begin
    hit_c = 1'b0;
    tgt_c = dest_q;
    idx_c = rr_ptr_q;
    if (mode_q) begin
      tgt_c = rr_ptr_q;
      for (int k = 0; k < 4; k++) begin
        idx_c = rr_ptr_q + 2'(k);
        if (!hit_c && out_ready[idx_c]) begin
          hit_c = 1'b1;
          tgt_c = idx_c;
        end
      end
    end else begin
      hit_c = out_ready[dest_q];
    end
  end

  assign xfer_c    = (state_q == HOLD) && hit_c;
  assign timeout_c = (TIMEOUT != 0) && (state_q == HOLD) && !hit_c &&
                     (wait_q == WAIT_W'(TO_M1));

  // Demux-facing outputs; round-robin valid/sel follow out_ready within the cycle.
  always_comb begin
    out_valid = 4'b0000;
    sel       = last_sel_q;
    if (state_q == HOLD) begin
      sel = tgt_c;
      if (!mode_q || hit_c) begin
        out_valid[tgt_c] = 1'b1;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_data   = data_q;
  assign drop_err   = drop_q;
  assign sent_count = cnt_q;

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    dest_d     = dest_q;
    mode_d     = mode_q;
    rr_ptr_d   = rr_ptr_q;
    last_sel_d = last_sel_q;
    wait_d     = wait_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q & ~clear_err;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          dest_d  = in_dest;
          mode_d  = rr_mode;
          wait_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (xfer_c) begin
          state_d    = IDLE;
          cnt_d      = cnt_q + CNT_W'(1);
          last_sel_d = tgt_c;
          if (mode_q) begin
            rr_ptr_d = tgt_c + 2'd1;
          end
        end else if (timeout_c) begin
          state_d = IDLE;
          drop_d  = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      dest_q     <= '0;
      mode_q     <= 1'b0;
      rr_ptr_q   <= '0;
      last_sel_q <= '0;
      wait_q     <= '0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      dest_q     <= dest_d;
      mode_q     <= mode_d;
      rr_ptr_q   <= rr_ptr_d;
      last_sel_q <= last_sel_d;
      wait_q     <= wait_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed and randomized checks of demux_dispatcher against a word-level model.
module tb_demux_dispatcher;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned TO    = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_dest;
  logic             in_valid;
  logic             in_ready;
  logic             rr_mode;
  logic [3:0]       out_ready;
  logic [3:0]       out_valid;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out_data;
  logic             drop_err;
  logic             clear_err;
  logic [CNT_W-1:0] sent_count;

  demux_dispatcher #(.WIDTH(WIDTH), .TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest),
    .in_valid(in_valid), .in_ready(in_ready), .rr_mode(rr_mode),
    .out_ready(out_ready), .out_valid(out_valid), .sel(sel),
    .out_data(out_data), .drop_err(drop_err), .clear_err(clear_err),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state, tracked per word.
  int unsigned exp_cnt  = 0;
  int unsigned exp_ptr  = 0;
  int unsigned exp_sel  = 0;
  logic        exp_drop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".sel"}, 32'(sel), 32'(exp_sel));
    chk({tag, ".count"}, 32'(sent_count), 32'(exp_cnt % (1 << CNT_W)));
    chk({tag, ".drop_err"}, 32'(drop_err), 32'(exp_drop));
  endtask

  // One word: capture cycle then up to TO hold cycles, out_ready per cycle from seq nibbles.
  task automatic send_word(input string tag, input logic mode, input logic [1:0] dest,
                           input logic [7:0] data, input logic [15:0] seq, input logic clr);
    logic        done;
    logic        hit;
    int unsigned t;
    logic [3:0]  r;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = data;
    in_dest   = dest;
    rr_mode   = mode;
    out_ready = 4'($urandom);
    clear_err = 1'b0;
    #1;
    check_idle({tag, ".cap"});
    @(posedge clk);
    done = 1'b0;
    for (int c = 0; c < int'(TO); c++) begin
      if (!done) begin
        @(negedge clk);
        r         = seq[c*4 +: 4];
        out_ready = r;
        in_valid  = 1'($urandom);
        in_data   = ~data;
        in_dest   = 2'($urandom);
        rr_mode   = 1'($urandom);
        clear_err = clr;
        if (clr) exp_drop = 1'b0;
        hit = 1'b0;
        t   = dest;
        if (mode) begin
          for (int j = 0; j < 4; j++) begin
            int unsigned i;
            i = (exp_ptr + j) % 4;
            if (!hit && r[i]) begin
              hit = 1'b1;
              t   = i;
            end
          end
        end else begin
          hit = r[dest];
        end
        #1;
        chk({tag, ".hold.in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, ".hold.out_data"}, 32'(out_data), 32'(data));
        chk({tag, ".hold.out_valid"}, 32'(out_valid),
            (!mode || hit) ? (32'd1 << t) : 32'd0);
        if (!mode || hit) chk({tag, ".hold.sel"}, 32'(sel), 32'(t));
        if (hit) begin
          exp_cnt++;
          exp_sel = t;
          if (mode) exp_ptr = (t + 1) % 4;
          done = 1'b1;
        end else if (c == int'(TO) - 1) begin
          exp_drop = 1'b1;
          done     = 1'b1;
        end
        @(posedge clk);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    clear_err = 1'b0;
    #1;
    check_idle({tag, ".end"});
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_dest = '0; in_valid = 1'b0;
    rr_mode = 1'b0; out_ready = '0; clear_err = 1'b0;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.sel", 32'(sel), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.drop_err", 32'(drop_err), 32'd0);
    chk("rst.count", 32'(sent_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Addressed delivery to sink 2.
    send_word("addr2", 1'b0, 2'd2, 8'hA5, 16'h4444, 1'b0);

    // Round-robin across all-ready sinks: 0,1,2,3,0.
    for (int w = 0; w < 5; w++) send_word("rr_all", 1'b1, 2'($urandom), 8'(8'h10 + w), 16'hFFFF, 1'b0);
    chk("rr_all.ptr_model", 32'(exp_ptr), 32'd1);

    // rr_ptr=1 with sinks 0 and 3 ready picks 3; then late ready on sink 0.
    send_word("rr_skip", 1'b1, 2'd0, 8'h3C, 16'h9999, 1'b0);
    send_word("rr_wait", 1'b1, 2'd0, 8'hC3, 16'h1000, 1'b0);

    // Timeout drop, then clear.
    send_word("drop", 1'b0, 2'd1, 8'h77, 16'h0000, 1'b0);
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    exp_drop  = 1'b0;
    #1;
    chk("clear.drop_err", 32'(drop_err), 32'd0);

    // Ready arriving on the final hold cycle wins over the timeout.
    send_word("late", 1'b0, 2'd1, 8'h5A, 16'h2000, 1'b0);

    // Drop while clear_err is held: set wins.
    send_word("drop_clr", 1'b0, 2'd3, 8'hE1, 16'h7777, 1'b1);
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    exp_drop  = 1'b0;

    // Randomized words with sparse readiness.
    for (int w = 0; w < 60; w++) begin
      logic [15:0] s;
      s = '0;
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 2) == 0) s[c*4 +: 4] = 4'($urandom);
      send_word("rand", 1'($urandom), 2'($urandom), 8'($urandom), s, 1'b0);
      if (exp_drop && $urandom_range(0, 1) == 1) begin
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        exp_drop  = 1'b0;
      end
    end

    // Reset asserted mid-hold discards the word immediately.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h99; in_dest = 2'd0; rr_mode = 1'b0; out_ready = '0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mid.hold_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.in_ready", 32'(in_ready), 32'd0);
    chk("mid.sel", 32'(sel), 32'd0);
    chk("mid.out_data", 32'(out_data), 32'd0);
    chk("mid.count", 32'(sent_count), 32'd0);
    chk("mid.drop_err", 32'(drop_err), 32'd0);
    exp_cnt = 0; exp_ptr = 0; exp_sel = 0; exp_drop = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("post.out_valid", 32'(out_valid), 32'd0);
      chk("post.count", 32'(sent_count), 32'd0);
    end
    send_word("post_rr", 1'b1, 2'd3, 8'h42, 16'h8888, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
